// File: rtl/my_arbiter8way16_if.sv
// Handshake bundle between eight 16-bit requesters, the round-robin arbiter
// and the single downstream consumer of the registered output word.
interface my_arbiter8way16_if;
  logic [15:0] in0;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [15:0] in3;
  logic [15:0] in4;
  logic [15:0] in5;
  logic [15:0] in6;
  logic [15:0] in7;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic [2:0]  sel;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  grant_id;

  modport master (
    output in0, in1, in2, in3, in4, in5, in6, in7, in_valid, out_ready,
    input  in_ready, sel, out, out_valid, grant_id
  );

  modport slave (
    input  in0, in1, in2, in3, in4, in5, in6, in7, in_valid, out_ready,
    output in_ready, sel, out, out_valid, grant_id
  );
endinterface

// File: rtl/my_arbiter8way16.sv
// Round-robin arbiter for eight 16-bit requesters feeding one registered
// output slot; a burst limit lets the current owner keep consecutive transfers.
module my_arbiter8way16 #(
  parameter int unsigned BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  my_arbiter8way16_if.slave io_bus
);
  localparam logic [3:0] CNT_MAX = 4'd15;

  logic [15:0] w_in [8];
  logic [2:0]  r_last;
  logic [3:0]  r_cnt;
  logic [2:0]  r_sel;
  logic [15:0] r_out;
  logic        r_out_valid;
  logic [2:0]  r_grant_id;
  logic [2:0]  w_grant;
  logic [2:0]  w_scan;
  logic        w_found;
  logic        w_others;
  logic        w_keep;
  logic        w_acc;

  assign w_in[0] = io_bus.in0;
  assign w_in[1] = io_bus.in1;
  assign w_in[2] = io_bus.in2;
  assign w_in[3] = io_bus.in3;
  assign w_in[4] = io_bus.in4;
  assign w_in[5] = io_bus.in5;
  assign w_in[6] = io_bus.in6;
  assign w_in[7] = io_bus.in7;

  assign w_others = |(io_bus.in_valid & ~(8'd1 << r_last));
  assign w_keep   = (r_cnt != 4'd0) && io_bus.in_valid[r_last] &&
                    (({28'd0, r_cnt} < BURST) || !w_others);
  assign w_acc    = (!r_out_valid || io_bus.out_ready) && (|io_bus.in_valid);

  // Scan starts one past the previous owner, so the owner itself is considered last.
  always_comb begin
    w_grant = r_last;
    w_found = 1'b0;
    w_scan  = r_last;
    if (!w_keep) begin
      for (int k = 1; k <= 8; k++) begin
        w_scan = r_last + 3'(k);
        if (!w_found && io_bus.in_valid[w_scan]) begin
          w_grant = w_scan;
          w_found = 1'b1;
        end
      end
    end
  end

  assign io_bus.in_ready  = (w_acc && !reset) ? (8'd1 << w_grant) : 8'd0;
  assign io_bus.sel       = (|io_bus.in_valid) ? w_grant : r_sel;
  assign io_bus.out       = r_out;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.grant_id  = r_grant_id;

  // A drained slot can be refilled in the same cycle, giving one word per clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out       <= 16'd0;
      r_out_valid <= 1'b0;
      r_grant_id  <= 3'd0;
      r_sel       <= 3'd0;
      r_last      <= 3'd7;
      r_cnt       <= 4'd0;
    end else begin
      if (|io_bus.in_valid) begin
        r_sel <= w_grant;
      end
      if (w_acc) begin
        r_out       <= w_in[w_grant];
        r_out_valid <= 1'b1;
        r_grant_id  <= w_grant;
        if ((w_grant == r_last) && (r_cnt != 4'd0)) begin
          if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 4'd1;
          end
        end else begin
          r_cnt  <= 4'd1;
          r_last <= w_grant;
        end
      end else if (io_bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_my_arbiter8way16.sv
// Bench for my_arbiter8way16: a BURST=4 and a BURST=1 instance share stimulus and
// are both compared every cycle against a queue-free behavioural model.
module tb_my_arbiter8way16;
  localparam int BURST_A = 4;
  localparam int BURST_B = 1;

  logic        clk;
  logic        rst;
  logic [7:0]  inValid;
  logic        outReady;
  logic [15:0] inData [8];
  int          nChecks;
  int          nFails;

  // Model of each instance's architectural state: 0 is BURST_A, 1 is BURST_B.
  int          mLast [2];
  int          mRun  [2];
  int          mSel  [2];
  int          mId   [2];
  logic        mFull [2];
  logic [15:0] mWord [2];

  typedef struct {
    logic        rst;
    logic [7:0]  inValid;
    logic        outReady;
    logic [7:0]  expInReady;
    logic        expOutValid;
    logic [15:0] expOut;
    logic [2:0]  expGrant;
  } vec_t;

  vec_t vecs [14];

  my_arbiter8way16_if bus4 ();
  my_arbiter8way16_if bus1 ();

  assign bus4.in0 = inData[0];
  assign bus4.in1 = inData[1];
  assign bus4.in2 = inData[2];
  assign bus4.in3 = inData[3];
  assign bus4.in4 = inData[4];
  assign bus4.in5 = inData[5];
  assign bus4.in6 = inData[6];
  assign bus4.in7 = inData[7];
  assign bus4.in_valid  = inValid;
  assign bus4.out_ready = outReady;
  assign bus1.in0 = inData[0];
  assign bus1.in1 = inData[1];
  assign bus1.in2 = inData[2];
  assign bus1.in3 = inData[3];
  assign bus1.in4 = inData[4];
  assign bus1.in5 = inData[5];
  assign bus1.in6 = inData[6];
  assign bus1.in7 = inData[7];
  assign bus1.in_valid  = inValid;
  assign bus1.out_ready = outReady;

  my_arbiter8way16 #(.BURST(BURST_A)) u_dut4 (.clk(clk), .reset(rst), .io_bus(bus4));
  my_arbiter8way16 #(.BURST(BURST_B)) u_dut1 (.clk(clk), .reset(rst), .io_bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] v, input logic o);
    rst      = r;
    inValid  = v;
    outReady = o;
  endtask

  function automatic int burstOf(input int d);
    return (d == 0) ? BURST_A : BURST_B;
  endfunction

  // Round-robin choice: keep the owner while its burst allows, else first valid after it.
  function automatic int modelGrant(input int d, input logic [7:0] v);
    int others;
    int idx;
    others = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i] && i != mLast[d]) others++;
    end
    if (mRun[d] > 0 && v[mLast[d]] && (mRun[d] < burstOf(d) || others == 0)) begin
      return mLast[d];
    end
    for (int k = 1; k <= 8; k++) begin
      idx = (mLast[d] + k) % 8;
      if (v[idx]) return idx;
    end
    return mLast[d];
  endfunction

  task automatic modelCheck();
    int          g;
    logic        acc;
    logic [7:0]  expReady;
    int          expSel;
    logic [7:0]  aReady;
    logic [2:0]  aSel;
    logic [15:0] aOut;
    logic        aValid;
    logic [2:0]  aId;
    for (int d = 0; d < 2; d++) begin
      g        = modelGrant(d, inValid);
      acc      = (!mFull[d] || outReady) && (inValid != 8'd0);
      expReady = (rst || !acc) ? 8'd0 : 8'(1 << g);
      expSel   = (inValid != 8'd0) ? g : mSel[d];
      aReady   = (d == 0) ? bus4.in_ready  : bus1.in_ready;
      aSel     = (d == 0) ? bus4.sel       : bus1.sel;
      aOut     = (d == 0) ? bus4.out       : bus1.out;
      aValid   = (d == 0) ? bus4.out_valid : bus1.out_valid;
      aId      = (d == 0) ? bus4.grant_id  : bus1.grant_id;
      checkOutput($sformatf("model%0d_in_ready", d), 32'(aReady), 32'(expReady));
      checkOutput($sformatf("model%0d_sel", d), 32'(aSel), 32'(expSel));
      checkOutput($sformatf("model%0d_out", d), 32'(aOut), 32'(mWord[d]));
      checkOutput($sformatf("model%0d_out_valid", d), 32'(aValid), 32'(mFull[d]));
      checkOutput($sformatf("model%0d_grant_id", d), 32'(aId), 32'(mId[d]));
      checkOutput($sformatf("model%0d_ready_subset", d), 32'((aReady & ~inValid) == 8'd0), 32'd1);
    end
  endtask

  task automatic modelUpdate();
    int   g;
    logic acc;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mFull[d] = 1'b0;
        mWord[d] = 16'd0;
        mId[d]   = 0;
        mSel[d]  = 0;
        mLast[d] = 7;
        mRun[d]  = 0;
      end else begin
        g   = modelGrant(d, inValid);
        acc = (!mFull[d] || outReady) && (inValid != 8'd0);
        if (inValid != 8'd0) mSel[d] = g;
        if (acc) begin
          mWord[d] = inData[g];
          mFull[d] = 1'b1;
          mId[d]   = g;
          if (g == mLast[d] && mRun[d] > 0) begin
            mRun[d] = (mRun[d] + 1 > 15) ? 15 : mRun[d] + 1;
          end else begin
            mRun[d]  = 1;
            mLast[d] = g;
          end
        end else if (outReady) begin
          mFull[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic sampleCycle();
    @(negedge clk);
    modelCheck();
  endtask

  task automatic advanceCycle();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic idleCycle(input logic r, input logic [7:0] v, input logic o);
    applyStimulus(r, v, o);
    sampleCycle();
    advanceCycle();
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    inData[0] = 16'hA5A5;
    for (int i = 1; i < 8; i++) inData[i] = 16'h0100 + 16'(i);

    // Expectations for the BURST=4 instance, worked out by hand from reset.
    vecs[0]  = '{1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 16'h0000, 3'd0};
    vecs[1]  = '{1'b0, 8'h01, 1'b1, 8'h01, 1'b0, 16'h0000, 3'd0};
    vecs[2]  = '{1'b0, 8'h03, 1'b1, 8'h01, 1'b1, 16'hA5A5, 3'd0};
    vecs[3]  = '{1'b0, 8'h03, 1'b1, 8'h01, 1'b1, 16'hA5A5, 3'd0};
    vecs[4]  = '{1'b0, 8'h03, 1'b1, 8'h01, 1'b1, 16'hA5A5, 3'd0};
    vecs[5]  = '{1'b0, 8'h03, 1'b1, 8'h02, 1'b1, 16'hA5A5, 3'd0};
    vecs[6]  = '{1'b0, 8'h03, 1'b0, 8'h00, 1'b1, 16'h0101, 3'd1};
    vecs[7]  = '{1'b0, 8'h03, 1'b0, 8'h00, 1'b1, 16'h0101, 3'd1};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 16'h0101, 3'd1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0101, 3'd1};
    vecs[10] = '{1'b0, 8'h02, 1'b0, 8'h02, 1'b0, 16'h0101, 3'd1};
    vecs[11] = '{1'b0, 8'h04, 1'b1, 8'h04, 1'b1, 16'h0101, 3'd1};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 16'h0102, 3'd2};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 16'h0102, 3'd2};

    applyStimulus(1'b1, 8'h00, 1'b1);
    @(posedge clk);
    modelUpdate();
    #1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].inValid, vecs[i].outReady);
      sampleCycle();
      checkOutput($sformatf("vec%0d_in_ready", i), 32'(bus4.in_ready), 32'(vecs[i].expInReady));
      checkOutput($sformatf("vec%0d_out_valid", i), 32'(bus4.out_valid), 32'(vecs[i].expOutValid));
      checkOutput($sformatf("vec%0d_out", i), 32'(bus4.out), 32'(vecs[i].expOut));
      checkOutput($sformatf("vec%0d_grant_id", i), 32'(bus4.grant_id), 32'(vecs[i].expGrant));
      advanceCycle();
    end

    // Stall with requester 7 owning the slot, then release: BURST=1 wraps to 0.
    idleCycle(1'b1, 8'h00, 1'b1);
    idleCycle(1'b0, 8'h80, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 8'hFF, 1'b0);
      sampleCycle();
      checkOutput("stall_ready_b4", 32'(bus4.in_ready), 32'h0);
      checkOutput("stall_ready_b1", 32'(bus1.in_ready), 32'h0);
      checkOutput("stall_out_b4", 32'(bus4.out), 32'h0107);
      checkOutput("stall_out_b1", 32'(bus1.out), 32'h0107);
      advanceCycle();
    end
    applyStimulus(1'b0, 8'hFF, 1'b1);
    sampleCycle();
    checkOutput("release_wrap_b1", 32'(bus1.in_ready), 32'h01);
    checkOutput("release_burst_b4", 32'(bus4.in_ready), 32'h80);
    advanceCycle();
    applyStimulus(1'b0, 8'h00, 1'b1);
    sampleCycle();
    checkOutput("release_out_b1", 32'(bus1.out), 32'hA5A5);
    checkOutput("release_gid_b1", 32'(bus1.grant_id), 32'd0);
    advanceCycle();

    // All requesters valid with BURST=1: strict rotation without bubbles.
    inData[0] = 16'h0100;
    idleCycle(1'b1, 8'h00, 1'b1);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 8'hFF, 1'b1);
      sampleCycle();
      if (k >= 1) begin
        checkOutput($sformatf("rotate%0d_out", k), 32'(bus1.out), 32'(16'h0100 + 16'((k - 1) % 8)));
        checkOutput($sformatf("rotate%0d_valid", k), 32'(bus1.out_valid), 32'd1);
      end
      advanceCycle();
    end

    // A lone requester keeps the slot indefinitely; the run counter saturates.
    idleCycle(1'b1, 8'h00, 1'b1);
    for (int k = 0; k < 20; k++) idleCycle(1'b0, 8'h01, 1'b1);
    applyStimulus(1'b0, 8'h03, 1'b1);
    sampleCycle();
    checkOutput("sat_cnt_b4", 32'(u_dut4.r_cnt), 32'd15);
    checkOutput("sat_switch_b4", 32'(bus4.in_ready), 32'h02);
    advanceCycle();

    // Reset with a word buffered discards it and restarts the pointer at 7.
    idleCycle(1'b0, 8'h80, 1'b1);
    applyStimulus(1'b1, 8'h80, 1'b0);
    sampleCycle();
    checkOutput("rst_ready_b4", 32'(bus4.in_ready), 32'h0);
    checkOutput("rst_ready_b1", 32'(bus1.in_ready), 32'h0);
    advanceCycle();
    applyStimulus(1'b0, 8'h00, 1'b0);
    sampleCycle();
    checkOutput("rst_valid_b4", 32'(bus4.out_valid), 32'd0);
    checkOutput("rst_out_b4", 32'(bus4.out), 32'h0);
    advanceCycle();
    applyStimulus(1'b0, 8'h0A, 1'b1);
    sampleCycle();
    checkOutput("rst_first_grant_b4", 32'(bus4.in_ready), 32'h02);
    advanceCycle();

    // Randomized traffic, both instances compared against the model each cycle.
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] v;
      for (int i = 0; i < 8; i++) inData[i] = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       v = 8'($urandom);
        1:       v = 8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7));
        2:       v = 8'($urandom) & 8'($urandom);
        default: v = 8'hFF;
      endcase
      idleCycle($urandom_range(0, 99) == 0, v, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/my_arbiter8way16.md
Name: my_arbiter8way16

Overview:
- Round-robin arbiter and sequencer for the shared 8-way 16-bit select datapath (my_mux8way16).
- Eight requesters each offer one 16-bit word with a valid/ready handshake.
- The arbiter picks one requester per transfer, drives the mux select, and registers the chosen word into a single-entry output buffer with its own valid/ready handshake.
- A configurable burst limit lets a requester keep the datapath for consecutive transfers while others wait.

Parameters:
BURST, 4, max consecutive transfers granted to one requester while any other requester is valid; legal range 1..15.

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in0..in7  input  16 each  requester data words (shortint)
in_valid  input  8  bit i = requester i offers in<i>
in_ready  output  8  one-hot or zero; bit i = in<i> accepted this cycle
sel  output  3  select presented to the 8-way mux; index of current grant
out  output  16  registered selected word
out_valid  output  1  out holds an unconsumed word
out_ready  input  1  consumer accepts out this cycle
grant_id  output  3  index of requester whose word is in out (valid while out_valid)

Behaviour:
- Reset (reset=1 at a clk edge): out=0, out_valid=0, grant_id=0, sel=0, rr pointer last=7, burst count cnt=0.
- in_ready is forced to 0 in any cycle where reset=1.
- Accept condition: acc = (!out_valid || out_ready) && |in_valid. Single output stage: a full buffer that is drained this cycle may accept a new word the same cycle, giving zero-bubble throughput of 1 word/cycle.
- Grant selection (combinational, every cycle):
  - Burst continuation: if cnt>0 and in_valid[last] and (cnt<BURST or no other bit of in_valid set), g=last.
  - Otherwise g = first i with in_valid[i]=1, scanning last+1, last+2, ... mod 8 (wraps 7->0). last itself is checked last.
  - sel=g whenever |in_valid; otherwise sel holds its previous value.
- Transfer cycle (acc=1):
  - in_ready = onehot(g).
  - On the edge: out<=in<g>, out_valid<=1, grant_id<=g.
  - Counter: if g==last && cnt>0, cnt<=cnt+1, saturating at 15. Else cnt<=1 and last<=g.
- Drain without accept (out_valid && out_ready && !acc): out_valid<=0. out, grant_id, last and cnt are held.
- Stall (out_valid && !out_ready): in_ready=0. out and out_valid are held stable; sel may change with in_valid.
- Burst break: when last drops in_valid, cnt is not reset. The next grant goes to another requester, which sets cnt<=1.
- Idle (in_valid==0): no state change except draining out_valid.
- Requesters may deassert in_valid at any time. An unaccepted word is simply not transferred; no lockup.
- Reset mid-transfer: a buffered word is discarded (out_valid<=0). No in_ready is asserted in the reset cycle.
- Latency: word accepted at edge N appears on out with out_valid=1 after edge N (1 cycle).
- Invariants:
  - in_ready has at most one bit set.
  - in_ready[i] implies in_valid[i].

Test Plan:
- Reset, then in_valid=8'h01, in0=16'hA5A5, out_ready=1 -> in_ready=8'h01 same cycle; next cycle out=16'hA5A5, out_valid=1, grant_id=0.
- All 8 valid (in<i>=16'h0100+i), BURST=1, out_ready=1 -> out sequence 0100,0101,...,0107,0100 on consecutive cycles; no bubbles.
- BURST=4, in_valid=8'h03, out_ready=1 -> grants 0,0,0,0,1,1,1,1,0 ...
- Same BURST=4 case with only requester 0 valid -> requester 0 granted every cycle past 4 transfers; cnt saturates at 15 with no wrap.
- out_valid=1, out_ready=0 for 5 cycles with in_valid=8'hFF -> in_ready=0 throughout; out stable. Then out_ready=1 -> next word accepted the same cycle, with grant from last+1 (wrap 7->0 checked).
- Assert reset while out_valid=1 and in_valid=8'h80 -> next cycle out_valid=0, out=0, in_ready=0 during reset. After release, first grant goes to requester 0 if valid, else the lowest valid index.
